// File: rtl/arb_pkg.sv
// Shared types and constants for the D/I request arbiter.
// Alignment rule for misaligned-request rejection lives here so sub-blocks agree.
package arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StResp = 2'b10
  } arb_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned REQ_D = 0;
  localparam int unsigned REQ_I = 1;

  // m_transfer = {valid, size[1:0]}
  localparam int unsigned XFER_VALID_BIT = 2;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = |addr_lo;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/arb_select.sv
// Combinational winner pick between D and I requesters; one-hot grant.
// ARB_ROUND_ROBIN_EN selects round-robin on rr_ptr, otherwise D has fixed priority.
module arb_select
  import arb_pkg::*;
(
  input  logic       d_req,
  input  logic       i_req,
  input  logic       rr_ptr,
  output logic [1:0] grant
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    grant = '0;
    if (d_req && i_req) begin
      // Pointer value equals the requester index it favours
      grant[rr_ptr] = 1'b1;
    end else if (d_req) begin
      grant[REQ_D] = 1'b1;
    end else if (i_req) begin
      grant[REQ_I] = 1'b1;
    end
  end
`else
  logic unused_rr_ptr;
  assign unused_rr_ptr = rr_ptr;

  always_comb begin
    grant = '0;
    if (d_req) begin
      grant[REQ_D] = 1'b1;
    end else if (i_req) begin
      grant[REQ_I] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/ahb_req_arbiter.sv
// Shares the AHB master's processor-side port between data (D) and fetch (I) requesters.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed D-over-I priority.
module ahb_req_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_write,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_size,
  output logic              d_done,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_size,
  output logic              i_done,
  output logic              i_err,
  output logic [DATA_W-1:0] i_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_write,
  output logic [DATA_W-1:0] m_wdata,
  output logic [2:0]        m_transfer,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  input  logic              m_resp
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              owner_q, owner_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0]        grant;
  logic              rr_ptr;

  logic [ADDR_W-1:0] sel_addr;
  logic              sel_write;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        sel_size;
  logic              sel_mis;

  arb_select u_select (
    .d_req  (d_req),
    .i_req  (i_req),
    .rr_ptr (rr_ptr),
    .grant  (grant)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ptr_q, rr_ptr_d;

  // Flip away from the favoured requester each time it wins, misaligned grants included
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == StIdle && grant[rr_ptr_q]) begin
      rr_ptr_d = ~rr_ptr_q;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rr_ptr_q <= 1'(REQ_D);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = 1'(REQ_D);
`endif

  // The I path is read-only, so its write/wdata are forced to zero
  always_comb begin
    if (grant[REQ_I]) begin
      sel_addr  = i_addr;
      sel_write = 1'b0;
      sel_wdata = '0;
      sel_size  = i_size;
    end else begin
      sel_addr  = d_addr;
      sel_write = d_write;
      sel_wdata = d_wdata;
      sel_size  = d_size;
    end
    sel_mis = is_misaligned(sel_size, sel_addr[1:0]);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    owner_d = owner_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (|grant) begin
          addr_d  = sel_addr;
          write_d = sel_write;
          wdata_d = sel_wdata;
          size_d  = sel_size;
          owner_d = grant[REQ_I];
          err_d   = sel_mis;
          rdata_d = '0;
          state_d = sel_mis ? StResp : StBusy;
        end
      end
      StBusy: begin
        if (m_ready) begin
          rdata_d = m_rdata;
          err_d   = m_resp;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      size_q  <= '0;
      owner_q <= 1'(REQ_D);
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      owner_q <= owner_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign m_addr  = addr_q;
  assign m_write = write_q;
  assign m_wdata = wdata_q;

  always_comb begin
    m_transfer = '0;
    if (state_q == StBusy) begin
      m_transfer[XFER_VALID_BIT] = 1'b1;
      m_transfer[1:0]            = size_q;
    end
  end

  always_comb begin
    d_done  = (state_q == StResp) && (owner_q == 1'(REQ_D));
    i_done  = (state_q == StResp) && (owner_q == 1'(REQ_I));
    d_err   = d_done & err_q;
    i_err   = i_done & err_q;
    d_rdata = d_done ? rdata_q : '0;
    i_rdata = i_done ? rdata_q : '0;
  end

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Directed bench for ahb_req_arbiter: vector table of single transactions plus
// hand sequences for reset mid-transfer and a winner dropping its request.
module tb_ahb_req_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          d_req, d_write, i_req;
  logic [AW-1:0] d_addr, i_addr;
  logic [DW-1:0] d_wdata;
  logic [1:0]    d_size, i_size;
  logic          d_done, d_err, i_done, i_err;
  logic [DW-1:0] d_rdata, i_rdata;
  logic [AW-1:0] m_addr;
  logic          m_write;
  logic [DW-1:0] m_wdata;
  logic [2:0]    m_transfer;
  logic [DW-1:0] m_rdata;
  logic          m_ready, m_resp;

  int n_vec = 0;
  int n_bad = 0;

  always #5 HCLK = ~HCLK;

  ahb_req_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .d_req      (d_req),
    .d_addr     (d_addr),
    .d_write    (d_write),
    .d_wdata    (d_wdata),
    .d_size     (d_size),
    .d_done     (d_done),
    .d_err      (d_err),
    .d_rdata    (d_rdata),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_size     (i_size),
    .i_done     (i_done),
    .i_err      (i_err),
    .i_rdata    (i_rdata),
    .m_addr     (m_addr),
    .m_write    (m_write),
    .m_wdata    (m_wdata),
    .m_transfer (m_transfer),
    .m_rdata    (m_rdata),
    .m_ready    (m_ready),
    .m_resp     (m_resp)
  );

  typedef struct {
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          d_write;
    logic [DW-1:0] d_wdata;
    logic [1:0]    d_size;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [1:0]    i_size;
    int            wait_cyc;
    logic [DW-1:0] m_rd;
    logic          m_rsp;
    logic          exp_i;    // expected winner is I
    logic          exp_mis;  // expected local misaligned rejection
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_vec(input vec_t v, input string tag);
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;
    logic          e_write, e_err;
    logic [1:0]    e_size;
    e_addr  = v.exp_i ? v.i_addr : v.d_addr;
    e_write = v.exp_i ? 1'b0 : v.d_write;
    e_wdata = v.exp_i ? '0 : v.d_wdata;
    e_size  = v.exp_i ? v.i_size : v.d_size;
    e_err   = v.exp_mis ? 1'b1 : v.m_rsp;
    e_rdata = v.exp_mis ? '0 : v.m_rd;
    d_req   = v.d_req;
    d_addr  = v.d_addr;
    d_write = v.d_write;
    d_wdata = v.d_wdata;
    d_size  = v.d_size;
    i_req   = v.i_req;
    i_addr  = v.i_addr;
    i_size  = v.i_size;
    @(negedge HCLK);
    if (!v.exp_mis) begin
      for (int c = 0; c <= v.wait_cyc; c++) begin
        check({tag, ".xfer"}, 64'(m_transfer), 64'({1'b1, e_size}));
        check({tag, ".addr"}, 64'(m_addr), 64'(e_addr));
        check({tag, ".write"}, 64'(m_write), 64'(e_write));
        check({tag, ".wdata"}, 64'(m_wdata), 64'(e_wdata));
        check({tag, ".early_done"}, 64'({d_done, i_done}), 64'd0);
        if (c == v.wait_cyc) begin
          m_ready = 1'b1;
          m_rdata = v.m_rd;
          m_resp  = v.m_rsp;
        end
        @(negedge HCLK);
      end
      m_ready = 1'b0;
      m_resp  = 1'b0;
      m_rdata = 32'hBAD0_BAD0;
    end
    check({tag, ".resp_xfer"}, 64'(m_transfer), 64'd0);
    check({tag, ".done"}, 64'({d_done, i_done}), 64'(v.exp_i ? 2'b01 : 2'b10));
    check({tag, ".err"}, 64'({d_err, i_err}), 64'(v.exp_i ? {1'b0, e_err} : {e_err, 1'b0}));
    check({tag, ".rdata"}, 64'(v.exp_i ? i_rdata : d_rdata), 64'(e_rdata));
    check({tag, ".other_rdata"}, 64'(v.exp_i ? d_rdata : i_rdata), 64'd0);
    d_req = 1'b0;
    i_req = 1'b0;
    @(negedge HCLK);
    check({tag, ".done_pulse"}, 64'({d_done, i_done}), 64'd0);
  endtask

  vec_t vecs[11];

  initial begin
    // D word read, ready after 2 wait cycles
    vecs[0] = '{1, 32'h0000_1000, 0, 32'h0, 2'b10, 0, 32'h0, 2'b10, 2, 32'hDEAD_BEEF, 0, 0, 0};
    // D half write to odd address: rejected locally
    vecs[1] = '{1, 32'h0000_2003, 1, 32'h1111, 2'b01, 0, 32'h0, 2'b10, 0, 32'h0, 0, 0, 1};
    // I fetch with bus error
    vecs[2] = '{0, 32'h0, 0, 32'h0, 2'b10, 1, 32'h0000_0100, 2'b10, 0, 32'h1234_5678, 1, 1, 0};
    // D byte write at odd address is aligned
    vecs[3] = '{1, 32'h0000_3001, 1, 32'h0000_00A5, 2'b00, 0, 32'h0, 2'b10, 1, 32'h55, 0, 0, 0};
    // I with illegal size 11
    vecs[4] = '{0, 32'h0, 0, 32'h0, 2'b10, 1, 32'h0000_0200, 2'b11, 0, 32'h0, 0, 1, 1};
    // Contention: both request each time
    vecs[5] = '{1, 32'h0000_4000, 0, 32'h0, 2'b10, 1, 32'h0000_8000, 2'b10, 0, 32'hA0A0_0005, 0, 0, 0};
    vecs[6] = '{1, 32'h0000_4004, 0, 32'h0, 2'b10, 1, 32'h0000_8004, 2'b10, 0, 32'hA0A0_0006, 0, RR, 0};
    vecs[7] = '{1, 32'h0000_4008, 0, 32'h0, 2'b10, 1, 32'h0000_8008, 2'b10, 1, 32'hA0A0_0007, 0, 0, 0};
    vecs[8] = '{1, 32'h0000_400C, 0, 32'h0, 2'b10, 1, 32'h0000_800C, 2'b10, 0, 32'hA0A0_0008, 0, RR, 0};
    // I aligned half fetch, 3 wait cycles
    vecs[9] = '{0, 32'h0, 0, 32'h0, 2'b10, 1, 32'h0000_0002, 2'b01, 3, 32'h0000_C0DE, 0, 1, 0};
    // D word at addr[1:0]=10: misaligned
    vecs[10] = '{1, 32'h0000_0012, 0, 32'h0, 2'b10, 0, 32'h0, 2'b10, 0, 32'h0, 0, 0, 1};

    HRESETn = 1'b0;
    d_req = 0; d_addr = '0; d_write = 0; d_wdata = '0; d_size = 2'b10;
    i_req = 0; i_addr = '0; i_size = 2'b10;
    m_ready = 0; m_resp = 0; m_rdata = 32'hBAD0_BAD0;
    repeat (2) @(negedge HCLK);
    check("rst.xfer", 64'(m_transfer), 64'd0);
    check("rst.addr", 64'(m_addr), 64'd0);
    check("rst.write_wdata", 64'({m_write, m_wdata}), 64'd0);
    check("rst.done", 64'({d_done, i_done, d_err, i_err}), 64'd0);
    check("rst.rdata", 64'({d_rdata, i_rdata}), 64'd0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    for (int k = 0; k < 11; k++) begin
      run_vec(vecs[k], $sformatf("v%0d", k));
    end

    // Reset while BUSY: outputs clear asynchronously and no done follows
    d_req = 1; d_addr = 32'h0000_5000; d_write = 0; d_size = 2'b10;
    @(negedge HCLK);
    check("rstmid.busy", 64'(m_transfer), 64'h6);
    #2 HRESETn = 1'b0;
    #1;
    check("rstmid.xfer_async", 64'(m_transfer), 64'd0);
    check("rstmid.addr_async", 64'(m_addr), 64'd0);
    d_req = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      check("rstmid.no_done", 64'({d_done, i_done}), 64'd0);
    end
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("rstmid.idle", 64'({m_transfer, d_done, i_done}), 64'd0);
    run_vec('{1, 32'h0000_5000, 0, 32'h0, 2'b10, 0, 32'h0, 2'b10, 0, 32'h0BAD_F00D, 0, 0, 0},
            "post_rst");

    // Winner drops req while BUSY: transfer still completes, single done
    d_req = 1; d_addr = 32'h0000_6000; d_write = 0; d_size = 2'b10;
    @(negedge HCLK);
    check("drop.busy", 64'(m_transfer), 64'h6);
    d_req = 0;
    @(negedge HCLK);
    check("drop.held", 64'(m_transfer), 64'h6);
    m_ready = 1; m_rdata = 32'hCAFE_F00D;
    @(negedge HCLK);
    m_ready = 0; m_rdata = 32'hBAD0_BAD0;
    check("drop.done", 64'({d_done, i_done}), 64'b10);
    check("drop.rdata", 64'(d_rdata), 64'hCAFE_F00D);
    @(negedge HCLK);
    check("drop.once", 64'({d_done, i_done}), 64'd0);
    @(negedge HCLK);
    check("drop.no_restart", 64'({m_transfer, d_done, i_done}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
